// File: rtl/aes_encipher_block.sv
`default_nettype none
// ============================================================================
// Module      : aes_encipher_block
// Description : Iterative AES encipher datapath and control. Performs the
//               initial AddRoundKey, the main rounds (SubBytes, ShiftRows,
//               MixColumns, AddRoundKey) and the final round without
//               MixColumns. SubBytes processes one 32-bit word per cycle
//               through an external forward S-box that is shared with key
//               expansion. AES-128 (10 rounds) and AES-256 (14 rounds) are
//               selected at run time.
// Ports       : clk        - clock, all state updates on posedge
//               reset_n    - asynchronous reset, active low
//               next       - start pulse, sampled only while idle
//               keylen     - 0 = AES-128, 1 = AES-256, latched on start
//               round      - current round number, addresses the key memory
//               round_key  - round key for the current round
//               sboxw      - word presented to the shared S-box (0 when unused)
//               new_sboxw  - S-box result for sboxw
//               block      - plaintext, must be stable during the INIT cycle
//               new_block  - state / ciphertext {w0,w1,w2,w3}
//               ready      - idle and new_block holds the result
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] w_q [0:3];
    logic [1:0]  sword_ctr_q;
    logic [3:0]  round_ctr_q;
    logic        keylen_q;
    logic        ready_q;

    logic [31:0] rk_w  [0:3];
    logic [31:0] blk_w [0:3];
    logic [31:0] sr_w  [0:3];
    logic [31:0] mc_w  [0:3];
    logic [3:0]  num_rounds;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return gf_mul2(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gf_mul2(b0) ^ gf_mul3(b1) ^ b2 ^ b3,
                b0 ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3,
                b0 ^ b1 ^ gf_mul2(b2) ^ gf_mul3(b3),
                gf_mul3(b0) ^ b1 ^ b2 ^ gf_mul2(b3)};
    endfunction

    // ------------------------------------------------------------------
    // Round transforms on the current state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rk_w[i]  = round_key[127 - 32*i -: 32];
            blk_w[i] = block[127 - 32*i -: 32];
        end

        // Row r of the state matrix (byte r of every word) rotates left by r
        sr_w[0] = {w_q[0][31:24], w_q[1][23:16], w_q[2][15:8], w_q[3][7:0]};
        sr_w[1] = {w_q[1][31:24], w_q[2][23:16], w_q[3][15:8], w_q[0][7:0]};
        sr_w[2] = {w_q[2][31:24], w_q[3][23:16], w_q[0][15:8], w_q[1][7:0]};
        sr_w[3] = {w_q[3][31:24], w_q[0][23:16], w_q[1][15:8], w_q[2][7:0]};

        for (int i = 0; i < 4; i++) begin
            mc_w[i] = mix_word(sr_w[i]);
        end
    end

    // Round count follows the latched key length so mid-run keylen changes
    // cannot alter an operation in progress.
    assign num_rounds = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;

    // ------------------------------------------------------------------
    // Control FSM and state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= 32'h0;
            end
            sword_ctr_q <= 2'd0;
            round_ctr_q <= 4'd0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (next) begin
                        round_ctr_q <= 4'd0;
                        keylen_q    <= keylen;
                        ready_q     <= 1'b0;
                        state_q     <= ST_INIT;
                    end
                end

                ST_INIT: begin
                    for (int i = 0; i < 4; i++) begin
                        w_q[i] <= blk_w[i] ^ rk_w[i];
                    end
                    round_ctr_q <= round_ctr_q + 4'd1;
                    sword_ctr_q <= 2'd0;
                    state_q     <= ST_SBOX;
                end

                ST_SBOX: begin
                    w_q[sword_ctr_q] <= new_sboxw;
                    sword_ctr_q      <= sword_ctr_q + 2'd1;
                    if (sword_ctr_q == 2'd3) begin
                        state_q <= ST_MAIN;
                    end
                end

                ST_MAIN: begin
                    sword_ctr_q <= 2'd0;
                    if (round_ctr_q < num_rounds) begin
                        for (int i = 0; i < 4; i++) begin
                            w_q[i] <= mc_w[i] ^ rk_w[i];
                        end
                        round_ctr_q <= round_ctr_q + 4'd1;
                        state_q     <= ST_SBOX;
                    end else begin
                        // Final round: no MixColumns; round stays at nr
                        for (int i = 0; i < 4; i++) begin
                            w_q[i] <= sr_w[i] ^ rk_w[i];
                        end
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sboxw     = (state_q == ST_SBOX) ? w_q[sword_ctr_q] : 32'h0;
    assign round     = round_ctr_q;
    assign new_block = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encipher_block
// Description : Directed-vector bench for aes_encipher_block. Models the
//               shared forward S-box and the key memory (expanded key indexed
//               by round) around the DUT and checks FIPS-197 / SP800-38A
//               results, latency, start/keylen immunity, async reset and
//               back-to-back operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_encipher_block;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_C1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_SP   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_SP    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic [127:0] sbox_rows [0:15] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk [0:15];

    // Shared S-box and key memory models
    assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                        sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};
    assign round_key = rk[round];

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // FIPS-197 key expansion into the key-memory model
    task automatic expand_key(input logic [255:0] key, input bit is256);
        logic [31:0] w [0:59];
        logic [31:0] temp;
        logic [7:0]  rcon;
        int          nk;
        int          nr;
        nk   = is256 ? 8 : 4;
        nr   = is256 ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++) begin
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // One operation; latency counts edges from the sampling edge until ready
    task automatic run_op(input string tag, input bit kl, input logic [127:0] exp,
                          input int exp_lat, input bit disturb);
        int cnt;
        int max_rnd;
        @(negedge clk);
        keylen = kl;
        next   = 1'b1;
        @(posedge clk);
        #1;
        next    = 1'b0;
        cnt     = 1;
        max_rnd = int'(round);
        check_eq({tag, "_busy"}, 128'(ready), 128'h0);
        while (!ready && cnt < 200) begin
            if (disturb && cnt == 20) begin
                next   = 1'b1;
                keylen = ~kl;
            end
            if (disturb && cnt == 21) next = 1'b0;
            @(posedge clk);
            #1;
            cnt++;
            if (int'(round) > max_rnd) max_rnd = int'(round);
        end
        keylen = kl;
        check_eq({tag, "_latency"}, 128'(cnt), 128'(exp_lat));
        check_eq({tag, "_result"}, new_block, exp);
        check_eq({tag, "_round_peak"}, 128'(max_rnd), kl ? 128'd14 : 128'd10);
        // Result must hold while idle
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_hold"}, new_block, exp);
    endtask

    initial begin
        int cnt;
        int bad;
        int phase;
        bit is_sbox;

        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                sbox_tab[r*16 + c] = sbox_rows[r][127 - 8*c -: 8];
            end
            rk[r] = 128'h0;
        end
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = 128'h0;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("rst_ready", 128'(ready), 128'h1);
        check_eq("rst_block", new_block, 128'h0);
        check_eq("rst_round", 128'(round), 128'h0);
        check_eq("rst_sboxw", 128'(sboxw), 128'h0);

        // 1. FIPS-197 C.1
        expand_key(KEY_C1, 1'b0);
        block = PT_FIPS;
        run_op("c1", 1'b0, CT_C1, 52, 1'b0);

        // 2. FIPS-197 C.3 AES-256
        expand_key(KEY_C3, 1'b1);
        run_op("c3", 1'b1, CT_C3, 72, 1'b0);

        // 3. SP800-38A ECB AES-128
        expand_key(KEY_SP, 1'b0);
        block = PT_SP;
        run_op("sp", 1'b0, CT_SP, 52, 1'b0);

        // 4. Extra start pulse and keylen toggle mid-run are ignored
        expand_key(KEY_C1, 1'b0);
        block = PT_FIPS;
        run_op("ignore", 1'b0, CT_C1, 52, 1'b1);

        // 5. Asynchronous reset mid-operation
        @(negedge clk);
        keylen = 1'b0;
        next   = 1'b1;
        @(posedge clk);
        #1;
        next = 1'b0;
        cnt  = 1;
        while (cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_ready", 128'(ready), 128'h1);
        check_eq("abort_block", new_block, 128'h0);
        check_eq("abort_round", 128'(round), 128'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_op("after_rst", 1'b0, CT_C1, 52, 1'b0);

        // 6. Back-to-back with next tied high; sboxw idle outside SBOX cycles
        bad = 0;
        @(negedge clk);
        keylen = 1'b0;
        next   = 1'b1;
        for (int j = 0; j < 104; j++) begin
            @(posedge clk);
            #1;
            phase   = j % 52;
            is_sbox = (phase >= 1) && (phase <= 50) && (((phase - 1) % 5) < 4);
            if (!is_sbox && sboxw !== 32'h0) bad++;
            if (j == 51) begin
                check_eq("b2b_ready1", 128'(ready), 128'h1);
                check_eq("b2b_result1", new_block, CT_C1);
                expand_key(KEY_SP, 1'b0);
                block = PT_SP;
            end
            if (j == 52) check_eq("b2b_restart", 128'(ready), 128'h0);
            if (j == 103) begin
                check_eq("b2b_ready2", 128'(ready), 128'h1);
                check_eq("b2b_result2", new_block, CT_SP);
            end
        end
        next = 1'b0;
        check_eq("sboxw_idle", 128'(bad), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
